muldiv_issue_arbiter: RTL and testbench
=======================================

Name: muldiv_issue_arbiter

Overview:
- Shares the single iterative 32x32 multiplier (`laji_mult`) between the two issue slots of the dual-issue MIPS pipeline.
- Accepts MULT/MULTU requests from slot 0 (older) and slot 1 (younger), sequences the multiplier's start/ready handshake, and owns the architectural HI/LO registers.
- Generates stall signals for requesters and for MFHI/MFLO readers while an operation is in flight.

Parameters:
- TIMEOUT, 64, max cycles in WAIT before the watchdog sets `err`.
- CW, 7, width of the watchdog cycle counter (must hold TIMEOUT).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  slot 0 / slot 1 multiply request; held until granted.
- a0, b0 / a1, b1  in  32 each  operands for slot 0 / slot 1.
- sgn0 / sgn1  in  1  signed select per slot (1 = MULT, 0 = MULTU).
- gnt0 / gnt1  out  1  one-cycle accept pulse per slot.
- flush  in  1  discard the in-flight result (branch mispredict / exception).
- mult_a, mult_b  out  32  operands to the multiplier.
- mult_start  out  1  start pulse to the multiplier.
- mult_signed  out  1  is_signed to the multiplier.
- mult_s  in  64  multiplier product.
- mult_ready  in  1  multiplier isready.
- hi, lo  out  32  architectural HI/LO.
- busy  out  1  operation in flight; MFHI/MFLO and further requests stall.
- done  out  1  one-cycle pulse on HI/LO update.
- err  out  1  sticky watchdog flag.

Behaviour:
- Reset (reset = 0, async): state IDLE; hi = lo = 0; gnt0 = gnt1 = mult_start = done = busy = err = 0; mult_a = mult_b = 0; mult_signed = 0; watchdog counter = 0.
- States:
  - IDLE -> LAUNCH -> WAIT -> COMMIT -> IDLE.
  - Any state -> IDLE on flush (except COMMIT, see below).
- IDLE:
  - If req0: gnt0 = 1, latch a0/b0/sgn0 into the mult_* registers, go to LAUNCH.
  - Else if req1: same with slot 1.
  - Both requesting: slot 0 wins (program order); gnt1 stays 0 and slot 1 stalls.
  - Grants are combinational in IDLE only; busy = 0 in IDLE.
- LAUNCH:
  - mult_start = 1 for exactly this cycle; busy = 1.
  - mult_ready is ignored this cycle, so a stale ready from the previous op is not sampled.
  - Counter cleared. Next state WAIT.
- WAIT:
  - busy = 1; counter increments each cycle.
  - On mult_ready = 1, capture mult_s and go to COMMIT.
  - When counter reaches TIMEOUT: set err (sticky until reset) and return to IDLE without updating HI/LO.
- COMMIT:
  - hi <= captured[63:32], lo <= captured[31:0]; done = 1; busy = 1.
  - Next state IDLE; HI/LO are visible the cycle after COMMIT.
- Issue rate: at most one op per (multiplier latency + 3) cycles. No back-to-back overlap; a request arriving in COMMIT is granted in the following IDLE cycle.
- flush:
  - In LAUNCH or WAIT: return to IDLE next cycle, HI/LO unchanged, no done.
  - The multiplier is not reset; its later ready is masked because the arbiter is not in WAIT.
  - A new op can then launch, and its LAUNCH cycle masks any stale ready.
  - flush in COMMIT is ignored (the op is already architecturally retired).
  - flush in IDLE suppresses grants that cycle.
- Width: the product is taken verbatim from the multiplier; the arbiter performs no sign handling beyond forwarding mult_signed.
- Async reset mid-operation: immediate return to reset values. The multiplier is reset by the same net.

Decomposition:
- Shared package `muldiv_pkg`:
  - state encoding (IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, COMMIT = 2'd3);
  - constants for slot IDs;
  - the default TIMEOUT.
- One natural sub-module, `muldiv_watchdog`: counter with clear, enable and expiry compare.
- Arbitration, FSM and the HI/LO register file remain in the top module.

Test Plan:
1. req0, a0 = 20, b0 = 30, sgn0 = 0 -> gnt0 pulses 1 cycle, mult_start 1 cycle later; after ready, done pulses and hi = 0x00000000, lo = 0x00000258 (600).
2. req0 and req1 asserted the same cycle (slot 0: 24*311 unsigned; slot 1: -24*311 signed) -> gnt0 first, gnt1 held 0 until IDLE.
   - Slot 0 result: hi = 0, lo = 0x00001D28.
   - Then slot 1 result: hi = 0xFFFFFFFF, lo = 0xFFFFE2D8.
3. req1 only, a1 = -24 (0xFFFFFFE8), b1 = 311, sgn1 = 0 -> hi = 0x00000136, lo = 0xFFFFE2D8; busy high from LAUNCH through COMMIT.
4. Start 311 * -24 signed, assert flush 5 cycles into WAIT -> IDLE next cycle, hi/lo keep the previous values, no done.
   - Issue 20*30 immediately after -> result 600; the stale ready from the flushed op is not committed.
5. Tie mult_ready = 0 with TIMEOUT = 64 -> err rises exactly 64 cycles after entering WAIT, FSM returns to IDLE, hi/lo unchanged, and the next request is still granted.
6. Drive reset low mid-WAIT -> all outputs at reset values within the same cycle (asynchronous); after release, a new req0 completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply issue arbiter: FSM encoding,
// issue-slot identifiers and default watchdog sizing.
package muldiv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_COMMIT = 2'd3
   } state_e;

   // Slot 0 is the older instruction in program order.
   localparam logic SLOT0 = 1'b0;
   localparam logic SLOT1 = 1'b1;

   localparam int unsigned TIMEOUT_DEFAULT = 64;
   localparam int unsigned CW_DEFAULT      = 7;

endpackage

// File: rtl/muldiv_watchdog.sv
// Cycle counter guarding the wait for the multiplier's ready.
// expired_o fires on the cycle whose increment would bring the count to
// TIMEOUT, so the owner reacts exactly TIMEOUT cycles after the count began.
module muldiv_watchdog
   import muldiv_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
   parameter int unsigned CW      = CW_DEFAULT
)(
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear has priority over counting.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {CW{1'b0}};
      end else if (en_i) begin
         cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/muldiv_issue_arbiter.sv
// Shares one iterative 32x32 multiplier between two issue slots, sequences
// its start/ready handshake, and holds the architectural HI/LO registers.
module muldiv_issue_arbiter
   import muldiv_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
   parameter int unsigned CW      = CW_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] a0,
   input  logic [31:0] b0,
   input  logic [31:0] a1,
   input  logic [31:0] b1,
   input  logic        sgn0,
   input  logic        sgn1,
   output logic        gnt0,
   output logic        gnt1,
   input  logic        flush,
   output logic [31:0] mult_a,
   output logic [31:0] mult_b,
   output logic        mult_start,
   output logic        mult_signed,
   input  logic [63:0] mult_s,
   input  logic        mult_ready,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        err
);

   state_e      state_q, state_d;
   logic [31:0] mult_a_q, mult_a_d;
   logic [31:0] mult_b_q, mult_b_d;
   logic        mult_signed_q, mult_signed_d;
   logic [63:0] prod_q, prod_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        err_q, err_d;

   logic        gnt0_s, gnt1_s;
   logic        sel_slot_s;
   logic        wd_clr_s, wd_en_s, wd_expired_s;

   muldiv_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CW      (CW)
   ) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (wd_clr_s),
      .en_i      (wd_en_s),
      .expired_o (wd_expired_s)
   );

   // Arbitration and FSM next-state; ready is only sampled in WAIT so a
   // stale ready from a flushed or previous op can never be committed.
   always_comb begin
      state_d       = state_q;
      mult_a_d      = mult_a_q;
      mult_b_d      = mult_b_q;
      mult_signed_d = mult_signed_q;
      prod_d        = prod_q;
      hi_d          = hi_q;
      lo_d          = lo_q;
      err_d         = err_q;
      gnt0_s        = 1'b0;
      gnt1_s        = 1'b0;
      wd_clr_s      = 1'b0;
      wd_en_s       = 1'b0;
      sel_slot_s    = req0 ? SLOT0 : SLOT1;
      case (state_q)
         ST_IDLE: begin
            if (flush || !(req0 || req1)) begin
               state_d = ST_IDLE;
            end else begin
               if (sel_slot_s == SLOT0) begin
                  gnt0_s        = 1'b1;
                  mult_a_d      = a0;
                  mult_b_d      = b0;
                  mult_signed_d = sgn0;
               end else begin
                  gnt1_s        = 1'b1;
                  mult_a_d      = a1;
                  mult_b_d      = b1;
                  mult_signed_d = sgn1;
               end
               state_d = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            wd_clr_s = 1'b1;
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            wd_en_s = 1'b1;
            if (flush) begin
               state_d = ST_IDLE;
            end else if (mult_ready) begin
               prod_d  = mult_s;
               state_d = ST_COMMIT;
            end else if (wd_expired_s) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_COMMIT: begin
            hi_d    = prod_q[63:32];
            lo_d    = prod_q[31:0];
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, operand, product and HI/LO registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         mult_a_q      <= 32'd0;
         mult_b_q      <= 32'd0;
         mult_signed_q <= 1'b0;
         prod_q        <= 64'd0;
         hi_q          <= 32'd0;
         lo_q          <= 32'd0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         mult_a_q      <= mult_a_d;
         mult_b_q      <= mult_b_d;
         mult_signed_q <= mult_signed_d;
         prod_q        <= prod_d;
         hi_q          <= hi_d;
         lo_q          <= lo_d;
         err_q         <= err_d;
      end
   end

   assign gnt0        = gnt0_s;
   assign gnt1        = gnt1_s;
   assign mult_a      = mult_a_q;
   assign mult_b      = mult_b_q;
   assign mult_signed = mult_signed_q;
   assign mult_start  = (state_q == ST_LAUNCH);
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_COMMIT);
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign err         = err_q;

endmodule

// File: tb/tb_muldiv_issue_arbiter.sv
// Directed bench for muldiv_issue_arbiter with a latency-based multiplier
// stand-in and a done-driven HI/LO scoreboard.
module tb_muldiv_issue_arbiter;

   localparam int LAT = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [31:0] a0 = 32'd0, b0 = 32'd0, a1 = 32'd0, b1 = 32'd0;
   logic        sgn0 = 1'b0, sgn1 = 1'b0;
   logic        flush = 1'b0;
   logic        gnt0, gnt1;
   logic [31:0] mult_a, mult_b;
   logic        mult_start, mult_signed;
   logic [63:0] mult_s;
   logic        mult_ready;
   logic [31:0] hi, lo;
   logic        busy, done, err;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];
   logic        tie_low = 1'b0;

   muldiv_issue_arbiter dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .sgn0(sgn0), .sgn1(sgn1),
      .gnt0(gnt0), .gnt1(gnt1),
      .flush(flush),
      .mult_a(mult_a), .mult_b(mult_b),
      .mult_start(mult_start), .mult_signed(mult_signed),
      .mult_s(mult_s), .mult_ready(mult_ready),
      .hi(hi), .lo(lo),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Multiplier stand-in: result after LAT cycles, ready held until next start.
   int          m_cnt;
   logic        m_run;
   logic [63:0] m_prod;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mult_ready <= 1'b0; mult_s <= 64'd0; m_run <= 1'b0; m_cnt <= 0; m_prod <= 64'd0;
      end else if (mult_start) begin
         logic [63:0] ea, eb;
         ea = mult_signed ? {{32{mult_a[31]}}, mult_a} : {32'd0, mult_a};
         eb = mult_signed ? {{32{mult_b[31]}}, mult_b} : {32'd0, mult_b};
         m_prod <= ea * eb;
         mult_ready <= 1'b0; m_run <= 1'b1; m_cnt <= LAT;
      end else if (m_run) begin
         if (m_cnt == 1) begin
            mult_s <= m_prod; mult_ready <= ~tie_low; m_run <= 1'b0;
         end
         m_cnt <= m_cnt - 1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Scoreboard monitor: a done pulse pops one expectation; HI/LO compared next cycle.
   logic        cmp_pend = 1'b0;
   logic [63:0] cmp_exp;
   always @(negedge clk) begin
      if (cmp_pend) begin
         chk("hilo", {hi, lo}, cmp_exp);
         cmp_pend = 1'b0;
      end
      if (reset && done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            cmp_exp = exp_q.pop_front();
            cmp_pend = 1'b1;
         end
      end
   end

   // Request one slot, wait (bounded) for its grant, then check the launch cycle.
   task automatic issue(input logic slot, input logic [31:0] a, input logic [31:0] b, input logic sgn);
      bit got = 1'b0;
      if (slot == 1'b0) begin req0 = 1'b1; a0 = a; b0 = b; sgn0 = sgn; end
      else begin req1 = 1'b1; a1 = a; b1 = b; sgn1 = sgn; end
      #1;
      for (int i = 0; i < 50; i++) begin
         if ((slot == 1'b0) ? gnt0 : gnt1) begin got = 1'b1; break; end
         @(negedge clk);
      end
      chk("grant", {63'd0, got}, 64'd1);
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      chk("launch_start", {63'd0, mult_start}, 64'd1);
      chk("launch_ops", {mult_signed, mult_a, mult_b}, {sgn, a, b});
   endtask

   // Bounded wait for done, verifying busy stays high through COMMIT.
   task automatic wait_done(input string name);
      bit seen = 1'b0;
      bit busy_ok = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) busy_ok = 1'b0;
         if (done) begin seen = 1'b1; break; end
      end
      chk({name, "_done"}, {63'd0, seen}, 64'd1);
      chk({name, "_busy"}, {63'd0, busy_ok}, 64'd1);
      @(negedge clk);
   endtask

   initial begin
      bit early;
      repeat (2) @(negedge clk);
      chk("reset_outs", {hi, lo}, 64'd0);
      chk("reset_ctl", {58'd0, gnt0, gnt1, mult_start, done, busy, err}, 64'd0);
      chk("reset_ops", {mult_signed, mult_a, mult_b}, 65'd0);
      reset = 1'b1;
      @(negedge clk);

      // 1: unsigned 20*30
      exp_q.push_back({32'h0, 32'h0000_0258});
      issue(1'b0, 32'd20, 32'd30, 1'b0);
      wait_done("t1");

      // 2: simultaneous requests, slot 0 first
      req0 = 1'b1; a0 = 32'd24; b0 = 32'd311; sgn0 = 1'b0;
      req1 = 1'b1; a1 = 32'hFFFF_FFE8; b1 = 32'd311; sgn1 = 1'b1;
      exp_q.push_back({32'h0, 32'h0000_1D28});
      exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_E2D8});
      #1;
      chk("t2_arb", {62'd0, gnt0, gnt1}, 64'd2);
      @(posedge clk); #1; req0 = 1'b0;
      early = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (gnt1 && busy) early = 1'b1;
         if (gnt1) break;
      end
      chk("t2_gnt1_late", {62'd0, early, gnt1}, 64'd1);
      chk("t2_gnt1_idle", {62'd0, busy, gnt0}, 64'd0);
      @(posedge clk); #1; req1 = 1'b0;
      @(negedge clk);
      chk("t2_launch", {62'd0, mult_start, mult_signed}, 64'd3);
      wait_done("t2");

      // 3: slot 1 unsigned 0xFFFFFFE8*311
      exp_q.push_back({32'h0000_0136, 32'hFFFF_E2D8});
      issue(1'b1, 32'hFFFF_FFE8, 32'd311, 1'b0);
      wait_done("t3");

      // 4: flush 5 cycles into WAIT, then 20*30
      issue(1'b0, 32'd311, 32'hFFFF_FFE8, 1'b1);
      @(posedge clk);
      repeat (5) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("t4_idle", {62'd0, busy, done}, 64'd0);
      chk("t4_hilo_kept", {hi, lo}, {32'h0000_0136, 32'hFFFF_E2D8});
      exp_q.push_back({32'h0, 32'h0000_0258});
      issue(1'b0, 32'd20, 32'd30, 1'b0);
      wait_done("t4");

      // 5: watchdog with ready tied low
      tie_low = 1'b1;
      issue(1'b1, 32'd5, 32'd7, 1'b0);
      @(posedge clk);
      repeat (64) @(negedge clk);
      chk("t5_pre_expiry", {62'd0, err, busy}, 64'd1);
      @(negedge clk);
      chk("t5_expiry", {62'd0, err, busy}, 64'd2);
      chk("t5_hilo_kept", {hi, lo}, {32'h0, 32'h0000_0258});
      tie_low = 1'b0;
      exp_q.push_back({32'h0, 32'h0000_000C});
      issue(1'b0, 32'd3, 32'd4, 1'b0);
      wait_done("t5");
      chk("t5_err_sticky", {63'd0, err}, 64'd1);

      // 6: async reset mid-WAIT
      issue(1'b0, 32'd9, 32'd9, 1'b0);
      @(posedge clk);
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("t6_async_hilo", {hi, lo}, 64'd0);
      chk("t6_async_ctl", {58'd0, gnt0, gnt1, mult_start, done, busy, err}, 64'd0);
      chk("t6_async_ops", {mult_signed, mult_a, mult_b}, 65'd0);
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      exp_q.push_back({32'h0, 32'h0000_0258});
      issue(1'b0, 32'd20, 32'd30, 1'b0);
      wait_done("t6");

      repeat (3) @(negedge clk);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
